// File: rtl/elevator_pkg.sv
// elevator_pkg
// Constants shared between elevator_call_latch and elevator, plus the
// floor distance helper used by the nearest-floor selector.
package elevator_pkg;

   localparam int FLOORS          = 5;
   localparam int FLOOR_W         = 3;
   localparam int DEBOUNCE_CYCLES = 4;

   // Unsigned absolute difference between two floor indices.
   function automatic logic [FLOOR_W-1:0] floor_dist(
      input logic [FLOOR_W-1:0] a,
      input logic [FLOOR_W-1:0] b
   );
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One call button: two-flop synchroniser, stability counter and debounced
// level register.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_btn   : raw asynchronous button
//   o_level : debounced level
//   o_rise  : high during the cycle whose closing edge raises o_level
module btn_debounce
   import elevator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             w_flip;

   // The counter is about to reach DEBOUNCE_CYCLES: accept the new level.
   assign w_flip = (r_sync != r_level) && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_meta <= i_btn;
         r_sync <= r_meta;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_level <= r_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   // Combinational so the pending latch sets on the same edge as the level.
   assign o_rise  = w_flip & r_sync;

endmodule

// File: rtl/elevator_call_latch.sv
// elevator_call_latch
// Debounces floor call buttons, latches calls until served and presents one
// one-hot target floor to the elevator controller.
//   clk           : clock
//   reset         : asynchronous active-low reset
//   btn           : raw call buttons, one per floor
//   current_floor : floor the car is at
//   door_open     : car standing with door open
//   req           : one-hot target floor (zero when none)
//   pending       : latched calls (button lamps)
//   served        : one-cycle pulse for each call cleared by service
//   any_pending   : OR of pending
//
// Target register
//   state | meaning
//   IDLE  | r_tgt == 0, loads the nearest surviving pending call
//   HOLD  | r_tgt != 0, frozen until its floor is served
module elevator_call_latch #(
   parameter int FLOORS          = elevator_pkg::FLOORS,
   parameter int FLOOR_W         = elevator_pkg::FLOOR_W,
   parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  btn,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               door_open,
   output logic [FLOORS-1:0]  req,
   output logic [FLOORS-1:0]  pending,
   output logic [FLOORS-1:0]  served,
   output logic               any_pending
);

   import elevator_pkg::*;

   logic [FLOORS-1:0]  w_level;
   logic [FLOORS-1:0]  w_rise;
   logic [FLOORS-1:0]  w_clr;
   logic [FLOORS-1:0]  w_cand;
   logic [FLOORS-1:0]  w_pick;
   logic [FLOOR_W-1:0] w_dist;
   logic [FLOOR_W-1:0] w_best;
   logic               w_found;

   logic [FLOORS-1:0]  r_pending;
   logic [FLOORS-1:0]  r_served;
   logic [FLOORS-1:0]  r_tgt;

   for (genvar g = 0; g < FLOORS; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_clk  (clk),
         .i_rst_n(reset),
         .i_btn  (btn[g]),
         .o_level(w_level[g]),
         .o_rise (w_rise[g])
      );
   end

   // Service mask; an out-of-range current_floor matches no bit.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < FLOORS; i++) begin
         w_clr[i] = door_open && (current_floor == FLOOR_W'(i));
      end
   end

   // Nearest surviving call; strict compare keeps the lower floor on a tie.
   // Calls being cleared this edge are excluded so the target never points
   // at a floor whose pending bit is dropping.
   always_comb begin
      w_cand  = r_pending & ~w_clr;
      w_pick  = '0;
      w_dist  = '0;
      w_best  = '0;
      w_found = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (w_cand[i]) begin
            w_dist = floor_dist(FLOOR_W'(i), current_floor);
            if (!w_found || (w_dist < w_best)) begin
               w_found   = 1'b1;
               w_best    = w_dist;
               w_pick    = '0;
               w_pick[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
         r_served  <= '0;
         r_tgt     <= '0;
      end else begin
         // Clear wins over a same-edge set.
         r_pending <= (r_pending | w_rise) & ~w_clr;
         r_served  <= r_pending & w_clr;
         if (r_tgt == '0) begin
            r_tgt <= w_pick;
         end else begin
            r_tgt <= r_tgt & ~w_clr;
         end
      end
   end

   assign req         = r_tgt;
   assign pending     = r_pending;
   assign served      = r_served;
   assign any_pending = |r_pending;

endmodule

// File: tb/tb_elevator_call_latch.sv
module tb_elevator_call_latch;

   localparam int FLOORS  = 5;
   localparam int FLOOR_W = 3;

   logic               clk;
   logic               reset;
   logic [FLOORS-1:0]  btn;
   logic [FLOOR_W-1:0] current_floor;
   logic               door_open;
   logic [FLOORS-1:0]  req;
   logic [FLOORS-1:0]  pending;
   logic [FLOORS-1:0]  served;
   logic               any_pending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string             tag;
      logic [FLOORS-1:0] req;
      logic [FLOORS-1:0] pend;
      logic [FLOORS-1:0] srv;
   } exp_t;

   exp_t sb[$];

   elevator_call_latch #(
      .FLOORS         (FLOORS),
      .FLOOR_W        (FLOOR_W),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn          (btn),
      .current_floor(current_floor),
      .door_open    (door_open),
      .req          (req),
      .pending      (pending),
      .served       (served),
      .any_pending  (any_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_out(input string tag, input logic [FLOORS-1:0] r,
                             input logic [FLOORS-1:0] p, input logic [FLOORS-1:0] s);
      exp_t e;
      e.tag  = tag;
      e.req  = r;
      e.pend = p;
      e.srv  = s;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e = sb.pop_front();
      assert (req === e.req) else begin
         errors++;
         $error("FAIL %s req: got %b expected %b", e.tag, req, e.req);
      end
      checks++;
      assert (pending === e.pend) else begin
         errors++;
         $error("FAIL %s pending: got %b expected %b", e.tag, pending, e.pend);
      end
      checks++;
      assert (served === e.srv) else begin
         errors++;
         $error("FAIL %s served: got %b expected %b", e.tag, served, e.srv);
      end
      checks++;
      assert (any_pending === (|e.pend)) else begin
         errors++;
         $error("FAIL %s any_pending: got %b expected %b", e.tag, any_pending, |e.pend);
      end
   endtask

   initial begin
      reset = 1'b0;
      btn = '0;
      current_floor = '0;
      door_open = 1'b0;

      // Reset state
      #2;
      expect_out("rst_init", 5'b00000, 5'b00000, 5'b00000); compare_out();
      tick(2);
      expect_out("rst_hold", 5'b00000, 5'b00000, 5'b00000); compare_out();
      reset = 1'b1;
      tick(1);
      expect_out("rst_rel", 5'b00000, 5'b00000, 5'b00000); compare_out();

      // Single call at floor 4 from floor 0
      btn = 5'b10000;
      expect_out("single_pre", 5'b00000, 5'b00000, 5'b00000);
      tick(5); compare_out();
      expect_out("single_pend", 5'b00000, 5'b10000, 5'b00000);
      tick(1); compare_out();
      expect_out("single_req", 5'b10000, 5'b10000, 5'b00000);
      tick(1); compare_out();
      tick(3);
      btn = '0;
      expect_out("single_hold", 5'b10000, 5'b10000, 5'b00000); compare_out();
      current_floor = 3'd4;
      door_open = 1'b1;
      expect_out("single_srv", 5'b00000, 5'b00000, 5'b10000);
      tick(1); compare_out();
      door_open = 1'b0;
      expect_out("single_srv_drop", 5'b00000, 5'b00000, 5'b00000);
      tick(1); compare_out();
      tick(8);

      // Glitch reject, then a 4-cycle pulse
      btn = 5'b00100;
      tick(3);
      btn = '0;
      expect_out("glitch3", 5'b00000, 5'b00000, 5'b00000);
      tick(10); compare_out();
      btn = 5'b00100;
      tick(4);
      btn = '0;
      expect_out("pulse4", 5'b00100, 5'b00100, 5'b00000);
      tick(6); compare_out();
      current_floor = 3'd2;
      door_open = 1'b1;
      expect_out("pulse4_srv", 5'b00000, 5'b00000, 5'b00100);
      tick(1); compare_out();
      door_open = 1'b0;
      tick(8);

      // Nearest selection with tie at floor 2
      btn = 5'b01010;
      expect_out("tie_pend", 5'b00000, 5'b01010, 5'b00000);
      tick(6); compare_out();
      expect_out("tie_req", 5'b00010, 5'b01010, 5'b00000);
      tick(1); compare_out();
      btn = '0;
      tick(8);
      current_floor = 3'd1;
      door_open = 1'b1;
      expect_out("tie_srv1", 5'b00000, 5'b01000, 5'b00010);
      tick(1); compare_out();
      door_open = 1'b0;
      expect_out("tie_next", 5'b01000, 5'b01000, 5'b00000);
      tick(1); compare_out();
      current_floor = 3'd3;
      door_open = 1'b1;
      expect_out("tie_srv3", 5'b00000, 5'b00000, 5'b01000);
      tick(1); compare_out();
      door_open = 1'b0;
      tick(2);

      // Hold: target floor 4 stays while a floor 3 call latches
      current_floor = 3'd0;
      btn = 5'b10000;
      tick(7);
      btn = '0;
      expect_out("hold_tgt", 5'b10000, 5'b10000, 5'b00000); compare_out();
      current_floor = 3'd2;
      tick(8);
      btn = 5'b01000;
      tick(7);
      btn = '0;
      expect_out("hold_keep", 5'b10000, 5'b11000, 5'b00000); compare_out();
      expect_out("hold_keep2", 5'b10000, 5'b11000, 5'b00000);
      tick(8); compare_out();
      current_floor = 3'd4;
      door_open = 1'b1;
      expect_out("hold_srv4", 5'b00000, 5'b01000, 5'b10000);
      tick(1); compare_out();
      door_open = 1'b0;
      expect_out("hold_next", 5'b01000, 5'b01000, 5'b00000);
      tick(1); compare_out();
      current_floor = 3'd3;
      door_open = 1'b1;
      tick(1);
      door_open = 1'b0;
      tick(8);

      // Clear wins over a same-edge set at the open floor
      current_floor = 3'd0;
      door_open = 1'b1;
      btn = 5'b00001;
      expect_out("clr_before", 5'b00000, 5'b00000, 5'b00000);
      tick(5); compare_out();
      expect_out("clr_edge", 5'b00000, 5'b00000, 5'b00000);
      tick(1); compare_out();
      door_open = 1'b0;
      expect_out("clr_held", 5'b00000, 5'b00000, 5'b00000);
      tick(4); compare_out();
      btn = '0;
      tick(8);

      // Out-of-range floor clears nothing, then async reset drops calls
      btn = 5'b10100;
      tick(7);
      btn = '0;
      expect_out("two_calls", 5'b00100, 5'b10100, 5'b00000); compare_out();
      current_floor = 3'd7;
      door_open = 1'b1;
      expect_out("oor_floor", 5'b00100, 5'b10100, 5'b00000);
      tick(1); compare_out();
      door_open = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      expect_out("rst_async", 5'b00000, 5'b00000, 5'b00000); compare_out();
      tick(2);
      reset = 1'b1;
      expect_out("rst_after", 5'b00000, 5'b00000, 5'b00000);
      tick(1); compare_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_call_latch.md
# elevator_call_latch

Upstream request stage for `elevator`: synchronises and debounces raw floor call buttons, latches each call until the car serves it, and presents a single one-hot target floor on `req`. `req` drives `elevator.req` directly. `current_floor` and `door_open` are fed back from the sensor and from `elevator`.

## Interface

Parameters:
- `FLOORS`, 5, number of floors; floor 0 is the ground floor.
- `FLOOR_W`, 3, width of the floor index; must satisfy 2^FLOOR_W >= FLOORS.
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronised samples needed to accept a level change (>= 1).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state when 0.
- `btn` input FLOORS: raw call buttons, asynchronous, active-high, one per floor.
- `current_floor` input FLOOR_W: floor the car is at.
- `door_open` input 1: from `elevator`; high while the car stands with the door open.
- `req` output FLOORS: one-hot target floor, or all zero when no target.
- `pending` output FLOORS: latched calls, for the button lamps.
- `served` output FLOORS: one-cycle pulse on the bit of a call cleared by service.
- `any_pending` output 1: OR of `pending`.

## Operation

- **Per-floor input path:**
  - Two-flop synchroniser `s[i]`.
  - Debounced level `d[i]`.
  - Counter `cnt[i]` of width clog2(DEBOUNCE_CYCLES+1).
- **Debounce:**
  - If `s[i] == d[i]`, `cnt[i]` is 0.
  - Otherwise `cnt[i]` increments.
  - When it would reach DEBOUNCE_CYCLES, `d[i]` takes `s[i]` and `cnt[i]` returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes `d[i]`.
- **Set:** a rising edge of `d[i]` sets `pending[i]`. A held button produces only one set. Pressing an already-pending floor has no effect.
- **Service clear:** when `door_open == 1` and `current_floor == i`, `pending[i]` clears and `served[i]` pulses for one cycle.
  - `served[i]` pulses only if `pending[i]` was 1.
  - `current_floor >= FLOORS` clears nothing.
- **Simultaneous set and clear on the same floor:** clear wins; `pending` stays 0. A call at the floor where the door is open is discarded.
- **Target register `tgt` (one-hot), with `req = tgt`:**
  - **IDLE** (`tgt == 0`): if the next-cycle `pending` is nonzero, load the pending floor with the smallest |floor − current_floor|. On a tie, take the lower floor.
  - **HOLD** (`tgt != 0`): `tgt` is frozen; new calls do not retarget it.
  - HOLD returns to IDLE when the targeted floor is served. `tgt` clears on the same edge as its `pending` bit.
- **Gap between targets:** `req` is all zero for at least one cycle between successive targets.
- **Invariant:** `tgt` always has zero or one bit set, and `tgt & ~pending == 0` one cycle after any edge.

## Timing

- **Reset values:** while `reset == 0`, `s`, `d`, `cnt`, `pending`, `tgt` and `served` are 0, so all outputs are 0.
- **Reset release:** the first update occurs at the first rising edge after release. Reset mid-operation drops all calls.
- **Press latency:** `btn` goes high before edge k and stays high. Then:
  - `pending[i]` is 1 after edge k+1+DEBOUNCE_CYCLES.
  - `req` is valid after edge k+2+DEBOUNCE_CYCLES, if idle.
- **Service latency:** `door_open` and `current_floor` are sampled at edge e. `pending[i]`, `tgt` and `served[i]` update at e. `served[i]` drops at e+1. A new `req` appears at e+1 if other calls are pending.
- **Outputs:** all registered. `any_pending` is combinational from registered `pending`.

## Structure

- **Shared package `elevator_pkg`:**
  - Constants `FLOORS` and `FLOOR_W`, shared with `elevator`.
  - Function `floor_dist(a, b)` returning an unsigned absolute difference of width FLOOR_W.
- **Sub-module `btn_debounce`:** synchroniser, counter and `d` register for one button. It outputs the level `d` and a one-cycle `rise` strobe, and is instantiated FLOORS times in a generate loop.
- **Top level:** the pending/served logic and the nearest-floor selector, a combinational loop over FLOORS with a tie-break to the lower index.

## Test plan

- **Reset:** assert `reset = 0` mid-run with pending calls. Required: `req`, `pending` and `served` are 0 asynchronously, and stay 0 one edge after release with `btn = 0`.
- **Single call:** `current_floor = 0`, `btn[4]` high for 10 cycles. Required: `pending = 5'b10000` after edge 5 and `req = 5'b10000` after edge 6. With `door_open = 1` at floor 4: `req = 0`, `pending = 0` and `served[4]` pulses for one cycle.
- **Glitch reject:** `btn[2]` high for 3 cycles. Required: `pending` stays 0. A 4-cycle pulse sets `pending[2]`.
- **Nearest selection with tie:** `current_floor = 2`, calls at floors 1 and 3 latched on the same edge. Required: `req = 5'b00010`.
  - After floor 1 is served: `req = 0` for one cycle, then `5'b01000`.
- **Hold:** target is floor 4, then a call at floor 3 latches while the car is at 2. Required: `req` stays `5'b10000` until floor 4 is served.
- **Clear wins:** `btn[0]` debounced rise on the same edge as `door_open = 1` with `current_floor = 0`. Required: `pending[0]` stays 0 and `served[0]` stays 0.
